// File: rtl/engine_pkg.sv
// rtl/engine_pkg.sv - shared state encodings and display helper for the engine power controller
package engine_pkg;

   // Power FSM states; the numeric values double as the power_state display code
   typedef enum logic [1:0] {
      POFF_S = 2'd0,
      ARM_S  = 2'd1,
      PON_S  = 2'd2,
      LOCK_S = 2'd3
   } power_state_t;

   // global_state value meaning park/idle mode
   localparam int MODE_IDLE = 0;

   // Seven-segment glyph (gfedcba, active high) for a power_state code: O, A, n, L
   function automatic logic [6:0] power_state_seg(input logic [1:0] code);
      logic [6:0] seg;
      case (code)
         2'd0:    seg = 7'b0111111;
         2'd1:    seg = 7'b1110111;
         2'd2:    seg = 7'b1010100;
         default: seg = 7'b0111000;
      endcase
      return seg;
   endfunction

endpackage

// File: rtl/engine_power_ctrl_tick_counter.sv
// rtl/engine_power_ctrl_tick_counter.sv - saturating tick counter with terminal-count strobe
module tick_counter #(
   parameter int W     = 16,
   parameter int LIMIT = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   input  logic         clr,
   output logic [W-1:0] cnt,
   output logic         term
);

   // LIMIT of 0 means the terminal count never fires
   localparam logic [W-1:0] LAST    = W'(LIMIT - 1);
   localparam logic [W-1:0] CNT_MAX = '1;

   assign term = (LIMIT != 0) && en && (cnt == LAST);

   // Count enabled ticks; clear wins over count, and the value sticks at all-ones
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         cnt <= '0;
      end else if (en && (cnt != CNT_MAX)) begin
         cnt <= cnt + W'(1);
      end
   end

endmodule

// File: rtl/engine_power_ctrl.sv
// rtl/engine_power_ctrl.sv - engine power enable FSM with hold-to-start, blink, idle auto-off and lockout
module engine_power_ctrl #(
   parameter int HOLD_TICKS  = 1000,
   parameter int IDLE_TICKS  = 30000,
   parameter int BLINK_TICKS = 250,
   parameter int CNT_W       = 16,
   parameter int MODE_W      = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              tick_ms,
   input  logic [MODE_W-1:0] global_state,
   input  logic              power_on,
   input  logic              power_off,
   input  logic              manual_power,
   input  logic              activity,
   output logic              next_power,
   output logic              power_light,
   output logic [1:0]        power_state
);
   import engine_pkg::*;

   power_state_t      state, state_next;
   logic [MODE_W-1:0] prev_mode;
   logic              blink_phase, phase_next;

   logic [CNT_W-1:0]  hold_cnt, idle_cnt, blink_cnt;
   logic              hold_term, idle_term, blink_term;
   logic              hold_clr, idle_clr, blink_clr;
   logic              leaving, mode_change, idle_timeout, in_park;
   logic              unused_cnts;

   assign mode_change  = (global_state != prev_mode);
   assign in_park      = (global_state == MODE_W'(MODE_IDLE));
   assign idle_timeout = idle_term && !activity;
   assign leaving      = (state_next != state);

   // Every counter restarts on any state exit so no count carries into the next state
   assign hold_clr  = (state != ARM_S) || leaving;
   assign idle_clr  = (state != PON_S) || leaving || activity;
   assign blink_clr = (state != ARM_S) || leaving || blink_term;

   tick_counter #(.W(CNT_W), .LIMIT(HOLD_TICKS)) u_hold (
      .clk  (clk),
      .rst  (rst),
      .en   (tick_ms),
      .clr  (hold_clr),
      .cnt  (hold_cnt),
      .term (hold_term)
   );

   tick_counter #(.W(CNT_W), .LIMIT(IDLE_TICKS)) u_idle (
      .clk  (clk),
      .rst  (rst),
      .en   (tick_ms),
      .clr  (idle_clr),
      .cnt  (idle_cnt),
      .term (idle_term)
   );

   tick_counter #(.W(CNT_W), .LIMIT(BLINK_TICKS)) u_blink (
      .clk  (clk),
      .rst  (rst),
      .en   (tick_ms),
      .clr  (blink_clr),
      .cnt  (blink_cnt),
      .term (blink_term)
   );

   // Only the terminal strobes drive behaviour; raw counts are kept for debug probing
   assign unused_cnts = ^{hold_cnt, idle_cnt, blink_cnt};

   // Next state and blink phase, in priority order: mode change, power_off, park release, idle, normal
   always_comb begin
      state_next = state;
      phase_next = blink_phase;
      if (mode_change) begin
         if ((state == ARM_S) || (state == PON_S)) begin
            state_next = LOCK_S;
         end
      end else if (power_off && ((state == ARM_S) || (state == PON_S))) begin
         state_next = LOCK_S;
      end else if ((state == PON_S) && in_park && !power_on && !manual_power) begin
         state_next = LOCK_S;
      end else if ((state == PON_S) && idle_timeout) begin
         state_next = LOCK_S;
      end else begin
         case (state)
            POFF_S: begin
               if (power_on) begin
                  state_next = ARM_S;
                  phase_next = 1'b1;
               end
            end
            ARM_S: begin
               if (!power_on) begin
                  state_next = POFF_S;
               end else if (hold_term) begin
                  state_next = PON_S;
               end else if (blink_term) begin
                  phase_next = ~blink_phase;
               end
            end
            LOCK_S: begin
               if (!power_on) begin
                  state_next = POFF_S;
               end
            end
            default: begin
               state_next = state;
            end
         endcase
      end
   end

   // State, mode history and outputs, all registered from the next-state values
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= POFF_S;
         prev_mode   <= '0;
         blink_phase <= 1'b0;
         next_power  <= 1'b0;
         power_light <= 1'b0;
      end else begin
         state       <= state_next;
         prev_mode   <= global_state;
         blink_phase <= phase_next;
         next_power  <= (state_next == PON_S);
         power_light <= (state_next == PON_S) || ((state_next == ARM_S) && phase_next);
      end
   end

   assign power_state = state;

endmodule

// File: tb/tb_engine_power_ctrl.sv
// tb/tb_engine_power_ctrl.sv - vector and scoreboard bench for engine_power_ctrl
module tb_engine_power_ctrl;
   import engine_pkg::*;

   logic       clk = 1'b0;
   logic       rst, tick_ms, power_on, power_off, manual_power, activity;
   logic [1:0] global_state;
   logic       next_power, power_light;
   logic [1:0] power_state;
   logic       next_power0, power_light0;
   logic [1:0] power_state0;

   always #5 clk = ~clk;

   engine_power_ctrl #(.HOLD_TICKS(4), .IDLE_TICKS(5), .BLINK_TICKS(2), .CNT_W(16), .MODE_W(2)) dut (
      .clk(clk), .rst(rst), .tick_ms(tick_ms), .global_state(global_state),
      .power_on(power_on), .power_off(power_off), .manual_power(manual_power), .activity(activity),
      .next_power(next_power), .power_light(power_light), .power_state(power_state)
   );

   engine_power_ctrl #(.HOLD_TICKS(4), .IDLE_TICKS(0), .BLINK_TICKS(2), .CNT_W(16), .MODE_W(2)) dut0 (
      .clk(clk), .rst(rst), .tick_ms(tick_ms), .global_state(global_state),
      .power_on(power_on), .power_off(power_off), .manual_power(manual_power), .activity(activity),
      .next_power(next_power0), .power_light(power_light0), .power_state(power_state0)
   );

   typedef struct {
      logic       rst, tick;
      logic [1:0] g;
      logic       on, off, man, act;
      logic       np, pl;
      logic [1:0] ps;
      logic       np0;
   } vec_t;

   vec_t vecs[$];
   vec_t sb[$];
   int   checks = 0;
   int   errors = 0;

   task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   task automatic vd(input bit r, t, input bit [1:0] g, input bit on, off, man, act,
                     input bit np, pl, input logic [1:0] ps, input bit np0);
      vec_t x;
      x.rst = r; x.tick = t; x.g = g; x.on = on; x.off = off; x.man = man; x.act = act;
      x.np = np; x.pl = pl; x.ps = ps; x.np0 = np0;
      vecs.push_back(x);
   endtask

   task automatic v(input bit r, t, input bit [1:0] g, input bit on, off, man, act,
                    input bit np, pl, input logic [1:0] ps);
      vd(r, t, g, on, off, man, act, np, pl, ps, np);
   endtask

   // OFF -> ARMING then four back-to-back ticks to ON, power_on held throughout
   task automatic arm4(input bit [1:0] g);
      v(0, 0, g, 1, 0, 0, 0, 0, 1, ARM_S);
      v(0, 1, g, 1, 0, 0, 0, 0, 1, ARM_S);
      v(0, 1, g, 1, 0, 0, 0, 0, 0, ARM_S);
      v(0, 1, g, 1, 0, 0, 0, 0, 0, ARM_S);
      v(0, 1, g, 1, 0, 0, 0, 1, 1, PON_S);
   endtask

   task automatic build_table();
      // reset, then hold with a tick every third cycle (entry tick not counted)
      v(1, 0, 0, 0, 0, 0, 0, 0, 0, POFF_S);
      v(0, 0, 0, 0, 0, 0, 0, 0, 0, POFF_S);
      v(0, 1, 0, 1, 0, 0, 0, 0, 1, ARM_S);
      v(0, 0, 0, 1, 0, 0, 0, 0, 1, ARM_S);
      v(0, 0, 0, 1, 0, 0, 0, 0, 1, ARM_S);
      v(0, 1, 0, 1, 0, 0, 0, 0, 1, ARM_S);
      v(0, 0, 0, 1, 0, 0, 0, 0, 1, ARM_S);
      v(0, 0, 0, 1, 0, 0, 0, 0, 1, ARM_S);
      v(0, 1, 0, 1, 0, 0, 0, 0, 0, ARM_S);
      v(0, 0, 0, 1, 0, 0, 0, 0, 0, ARM_S);
      v(0, 0, 0, 1, 0, 0, 0, 0, 0, ARM_S);
      v(0, 1, 0, 1, 0, 0, 0, 0, 0, ARM_S);
      v(0, 0, 0, 1, 0, 0, 0, 0, 0, ARM_S);
      v(0, 0, 0, 1, 0, 0, 0, 0, 0, ARM_S);
      v(0, 1, 0, 1, 0, 0, 0, 1, 1, PON_S);
      v(0, 0, 0, 1, 0, 0, 0, 1, 1, PON_S);
      // power_off pulse with power_on held: lockout until release
      v(0, 0, 0, 1, 1, 0, 0, 0, 0, LOCK_S);
      v(0, 0, 0, 1, 0, 0, 0, 0, 0, LOCK_S);
      v(0, 1, 0, 1, 0, 0, 0, 0, 0, LOCK_S);
      v(0, 0, 0, 0, 0, 0, 0, 0, 0, POFF_S);
      v(0, 0, 0, 0, 0, 0, 0, 0, 0, POFF_S);
      // release after three ticks, then a re-press needs four fresh ticks
      v(0, 0, 0, 1, 0, 0, 0, 0, 1, ARM_S);
      v(0, 1, 0, 1, 0, 0, 0, 0, 1, ARM_S);
      v(0, 1, 0, 1, 0, 0, 0, 0, 0, ARM_S);
      v(0, 1, 0, 1, 0, 0, 0, 0, 0, ARM_S);
      v(0, 0, 0, 0, 0, 0, 0, 0, 0, POFF_S);
      v(0, 0, 0, 1, 0, 0, 0, 0, 1, ARM_S);
      v(0, 1, 0, 1, 0, 0, 0, 0, 1, ARM_S);
      v(0, 1, 0, 1, 0, 0, 0, 0, 0, ARM_S);
      v(0, 1, 0, 1, 0, 0, 0, 0, 0, ARM_S);
      v(0, 0, 0, 1, 0, 0, 0, 0, 0, ARM_S);
      v(0, 1, 0, 1, 0, 0, 0, 1, 1, PON_S);
      // mode change in ON locks out; mode change in OFF leaves OFF and blocks same-cycle arm
      v(0, 0, 2, 1, 0, 0, 0, 0, 0, LOCK_S);
      v(0, 0, 2, 1, 0, 0, 0, 0, 0, LOCK_S);
      v(0, 0, 2, 0, 0, 0, 0, 0, 0, POFF_S);
      v(0, 0, 1, 1, 0, 0, 0, 0, 0, POFF_S);
      arm4(1);
      v(0, 0, 2, 1, 0, 0, 0, 0, 0, LOCK_S);
      v(0, 0, 2, 0, 0, 0, 0, 0, 0, POFF_S);
      // park mode: manual_power keeps ON after release, dropping it locks out
      v(0, 0, 0, 0, 0, 0, 0, 0, 0, POFF_S);
      arm4(0);
      v(0, 0, 0, 0, 0, 1, 0, 1, 1, PON_S);
      v(0, 0, 0, 0, 0, 0, 0, 0, 0, LOCK_S);
      v(0, 0, 0, 0, 0, 0, 0, 0, 0, POFF_S);
      // idle timeout on the fifth quiet tick; the IDLE_TICKS=0 instance stays on
      arm4(0);
      v(0, 1, 0, 1, 0, 0, 0, 1, 1, PON_S);
      v(0, 1, 0, 1, 0, 0, 0, 1, 1, PON_S);
      v(0, 1, 0, 1, 0, 0, 0, 1, 1, PON_S);
      v(0, 1, 0, 1, 0, 0, 0, 1, 1, PON_S);
      vd(0, 1, 0, 1, 0, 0, 0, 0, 0, LOCK_S, 1);
      vd(0, 0, 0, 0, 0, 0, 0, 0, 0, POFF_S, 0);
      vd(0, 0, 0, 0, 0, 0, 0, 0, 0, POFF_S, 0);
      // activity on the fourth tick restarts the idle count
      arm4(0);
      v(0, 1, 0, 1, 0, 0, 0, 1, 1, PON_S);
      v(0, 1, 0, 1, 0, 0, 0, 1, 1, PON_S);
      v(0, 1, 0, 1, 0, 0, 0, 1, 1, PON_S);
      v(0, 1, 0, 1, 0, 0, 1, 1, 1, PON_S);
      for (int k = 0; k < 4; k++) v(0, 1, 0, 1, 0, 0, 0, 1, 1, PON_S);
      vd(0, 1, 0, 1, 0, 0, 0, 0, 0, LOCK_S, 1);
      vd(0, 0, 0, 0, 0, 0, 0, 0, 0, POFF_S, 0);
      v(0, 0, 0, 0, 0, 0, 0, 0, 0, POFF_S);
      // reset mid-ARMING and mid-ON together with tick and power_off
      v(0, 0, 0, 1, 0, 0, 0, 0, 1, ARM_S);
      v(0, 1, 0, 1, 0, 0, 0, 0, 1, ARM_S);
      v(1, 1, 0, 1, 1, 0, 0, 0, 0, POFF_S);
      arm4(0);
      v(1, 1, 0, 1, 1, 0, 0, 0, 0, POFF_S);
      v(0, 0, 0, 0, 0, 0, 0, 0, 0, POFF_S);
   endtask

   initial begin
      vec_t x, e;
      int   ticks;
      bit   seen;

      rst = 1'b1; tick_ms = 1'b0; global_state = 2'd0; power_on = 1'b0;
      power_off = 1'b0; manual_power = 1'b0; activity = 1'b0;
      build_table();

      foreach (vecs[i]) begin
         @(negedge clk);
         x = vecs[i];
         rst = x.rst; tick_ms = x.tick; global_state = x.g; power_on = x.on;
         power_off = x.off; manual_power = x.man; activity = x.act;
         sb.push_back(x);
         @(posedge clk);
         #1;
         e = sb.pop_front();
         chk($sformatf("v%0d next_power", i), {7'd0, next_power}, {7'd0, e.np});
         chk($sformatf("v%0d power_light", i), {7'd0, power_light}, {7'd0, e.pl});
         chk($sformatf("v%0d power_state", i), {6'd0, power_state}, {6'd0, e.ps});
         chk($sformatf("v%0d next_power_noidle", i), {7'd0, next_power0}, {7'd0, e.np0});
      end

      // Irregular tick spacing: power must rise right after the fourth counted tick
      @(negedge clk);
      rst = 1'b0; power_on = 1'b1; tick_ms = 1'b1; global_state = 2'd0;
      @(posedge clk);
      #1;
      chk("lat_arming", {6'd0, power_state}, {6'd0, ARM_S});
      ticks = 0;
      seen  = 1'b0;
      for (int c = 0; c < 200 && !seen; c++) begin
         @(negedge clk);
         tick_ms = ($urandom_range(0, 2) == 0);
         if (tick_ms) ticks++;
         @(posedge clk);
         #1;
         if (next_power) begin
            seen = 1'b1;
            chk("lat_ticks", 8'(ticks), 8'd4);
            chk("lat_edge", {7'd0, tick_ms}, 8'd1);
         end
      end
      if (!seen) chk("lat_timeout", 8'd0, 8'd1);

      // Long quiet stretch: IDLE_TICKS=5 locks out, IDLE_TICKS=0 stays on
      for (int k = 0; k < 12; k++) begin
         @(negedge clk); tick_ms = 1'b1;
         @(negedge clk); tick_ms = 1'b0;
      end
      @(posedge clk);
      #1;
      chk("quiet_lockout", {6'd0, power_state}, {6'd0, LOCK_S});
      chk("quiet_noidle_state", {6'd0, power_state0}, {6'd0, PON_S});
      chk("quiet_noidle_power", {7'd0, next_power0}, 8'd1);

      @(negedge clk);
      rst = 1'b1; power_on = 1'b0;
      @(posedge clk);
      #1;
      chk("final_reset_state", {6'd0, power_state0}, {6'd0, POFF_S});
      chk("final_reset_light", {7'd0, power_light0}, 8'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
